stream_checker: RTL
===================

STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width of the actual and expected streams.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of actual-data FIFO entries; it must be a power of 2, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse that clears all state and arms the checker.
REQ-006 SHALL have port act_valid  input  1  qualifies act_data from the upstream DUT; there is no backpressure.
REQ-007 SHALL have port act_data  input  WIDTH  DUT result word.
REQ-008 SHALL have port exp_valid  input  1  expected word available.
REQ-009 SHALL have port exp_data  input  WIDTH  expected result word.
REQ-010 SHALL have port exp_ready  output  1  the checker accepts exp_data this cycle.
REQ-011 SHALL have port cmp_valid  output  1  one-cycle pulse: a comparison result is present.
REQ-012 SHALL have port cmp_pass  output  1  result of the last comparison (1 = equal).
REQ-013 SHALL have port last_got / last_exp  output  WIDTH each  operands of the last comparison.
REQ-014 SHALL have port match_cnt / mismatch_cnt  output  16 each  comparison counters.
REQ-015 SHALL have port err  output  1  sticky; any mismatch since start.
REQ-016 SHALL have port overflow  output  1  sticky; an actual word was dropped.
REQ-017 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-018 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, HALT=2.

Function
REQ-019 SHALL implement the FSM: IDLE -> RUN on start; RUN -> HALT on a mismatch (only when STREAM_CHECKER_HALT_EN is defined); any state -> RUN on start.
REQ-020 SHALL, on start, empty the FIFO and zero the counters, err, overflow, cmp_valid, cmp_pass, last_got and last_exp, all at the same edge.
REQ-021 SHALL, in IDLE, ignore act_valid and hold exp_ready=0.
REQ-022 SHALL, in RUN and HALT, push act_data into the FIFO on every edge where act_valid=1, subject to REQ-024.
REQ-023 SHALL drive exp_ready combinationally as (state==RUN) && (level!=0).
REQ-024 SHALL, when the FIFO is full, act_valid=1 and no pop occurs, drop the word, leave level unchanged and set overflow; a push and a pop at the same edge while full SHALL be legal, with no overflow.
REQ-025 SHALL treat a pop as exp_valid && exp_ready at an edge; the pop SHALL compare the FIFO head against exp_data using full-width equality.
REQ-026 SHALL, at the pop edge, register cmp_valid=1, cmp_pass, last_got (head) and last_exp; cmp_valid SHALL be 0 at every other edge.
REQ-027 SHALL increment match_cnt or mismatch_cnt at the pop edge; both counters SHALL saturate at 16'hFFFF without wrap.
REQ-028 SHALL set err at a mismatch pop edge; err is cleared only by start or reset.
REQ-029 SHALL make a word pushed at edge N eligible for pop no earlier than edge N+1; the minimum act_valid-to-cmp_valid latency is 1 cycle.
REQ-030 SHALL wrap the FIFO read and write pointers modulo DEPTH; level SHALL equal pushes minus pops minus drops.
REQ-031 SHALL give start priority over a simultaneous push, pop or mismatch in the same cycle; those events SHALL be discarded.

Reset
REQ-032 SHALL, on rst_n low, immediately force state=IDLE, level=0, cmp_valid=0, cmp_pass=0, last_got=0, last_exp=0, both counters=0, err=0 and overflow=0, independent of clk.
REQ-033 SHALL, on reset assertion mid-stream, discard in-flight FIFO contents; after release the checker stays in IDLE until start.

Configuration
REQ-034 SHALL use macro STREAM_CHECKER_HALT_EN.
- Defined: the first mismatch moves the FSM to HALT; exp_ready is then 0; the FIFO keeps accepting words until full, then overflow may set; last_got and last_exp retain the failing pair.
- Undefined: the FSM never enters HALT, and mismatches are counted while checking continues.

Verification
REQ-035 SHALL cover: start; act_data 0x00000001 and exp_data 0x00000001 with exp_valid held -> cmp_valid pulse 1 cycle after the push, cmp_pass=1, match_cnt=1, err=0.
REQ-036 SHALL cover: act 0x12345679 vs exp 0x12345678 -> cmp_pass=0, mismatch_cnt=1, err=1; with HALT_EN, state=2 and exp_ready=0 thereafter.
REQ-037 SHALL cover: exp_valid=0 while 9 act words arrive with DEPTH=8 -> level=8, overflow=1; then 8 matching exp words -> match_cnt=8, level=0.
REQ-038 SHALL cover: full FIFO with act_valid and a pop in the same cycle -> level stays 8, overflow=0.
REQ-039 SHALL cover: rst_n low mid-stream with level=5 -> level=0 and state=0 immediately; act_valid is ignored until start.
REQ-040 SHALL cover: 70000 matching pairs -> match_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/stream_checker.sv
// Scoreboard checker: buffers DUT result words in a FIFO and compares them in order
// against an expected stream. Optional macro STREAM_CHECKER_HALT_EN stops checking at the first mismatch.
module stream_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     act_valid,
    input  logic [WIDTH-1:0]         act_data,
    input  logic                     exp_valid,
    input  logic [WIDTH-1:0]         exp_data,
    output logic                     exp_ready,
    output logic                     cmp_valid,
    output logic                     cmp_pass,
    output logic [WIDTH-1:0]         last_got,
    output logic [WIDTH-1:0]         last_exp,
    output logic [15:0]              match_cnt,
    output logic [15:0]              mismatch_cnt,
    output logic                     err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] head;
    logic             full, pop, push_req, push, drop, mismatch;

    // Expected-side handshake: a word transfers at a rising edge where exp_valid && exp_ready;
    // exp_ready never depends on exp_valid. The actual side has no backpressure at all.
    assign exp_ready = (state_q == RUN) && (level_q != '0);
    assign pop       = exp_valid && exp_ready;
    assign full      = (level_q == LW'(DEPTH));
    assign push_req  = act_valid && (state_q != IDLE);
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign head      = mem[rd_ptr];
    assign mismatch  = pop && (head != exp_data);

    assign level = level_q;
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
`ifdef STREAM_CHECKER_HALT_EN
            if (state_q == RUN && mismatch) state_d = HALT;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Storage carries no reset; occupancy is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push && !start) mem[wr_ptr] <= act_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            cmp_valid    <= 1'b0;
            cmp_pass     <= 1'b0;
            last_got     <= '0;
            last_exp     <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err          <= 1'b0;
            overflow     <= 1'b0;
        end else if (start) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            cmp_valid    <= 1'b0;
            cmp_pass     <= 1'b0;
            last_got     <= '0;
            last_exp     <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err          <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
            if (drop) overflow <= 1'b1;
            cmp_valid <= pop;
            if (pop) begin
                cmp_pass <= !mismatch;
                last_got <= head;
                last_exp <= exp_data;
                if (mismatch) begin
                    err <= 1'b1;
                    if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 1'b1;
                end else begin
                    if (match_cnt != 16'hFFFF) match_cnt <= match_cnt + 1'b1;
                end
            end
        end
    end
endmodule
